// File: rtl/cpu_pkg.sv
// Shared types and encodings for the single-cycle RV32I-subset core.
package cpu_pkg;

    typedef enum logic [2:0] {
        ADD = 3'd0,
        SUB = 3'd1,
        AND = 3'd2,
        OR  = 3'd3,
        XOR = 3'd4,
        SLL = 3'd5,
        SRL = 3'd6,
        SLT = 3'd7
    } alu_op_t;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    function automatic logic [31:0] sext12(input logic [11:0] v);
        return {{20{v[11]}}, v};
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; shifts use only b[4:0], SLT is a signed compare.
module alu
    import cpu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_t     alu_op,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        case (alu_op)
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            SLL:     result = a << b[4:0];
            SRL:     result = a >> b[4:0];
            SLT:     result = {31'd0, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instruction_memory.sv
// 32-word program store, captured from the program image while reset is high.
module instruction_memory
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc,
    input  logic [31:0][31:0] initial_instructions,
    output logic [31:0]       instruction
);

    logic [31:0][31:0] r_mem;
    logic              w_pc_unused;

    // No write port: contents only change when reset reloads the image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem <= initial_instructions;
        end
    end

    // Fetch wraps every 128 bytes.
    assign instruction = r_mem[pc[6:2]];
    assign w_pc_unused = ^{pc[31:7], pc[1:0]};

endmodule

// File: rtl/cpu_core.sv
// Single-cycle RV32I-subset core (ADD/SUB/logic/shift/SLT, R and I forms).
// Define CPU_CORE_DEBUG_EN to expose the *_check observation ports.
module cpu_core
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0][31:0] initial_instructions,
    input  logic [31:0][31:0] initial_register_values
`ifdef CPU_CORE_DEBUG_EN
    ,
    output logic [31:0][31:0] register_check,
    output logic [31:0]       pc_out_check,
    output logic [31:0]       instruction_check,
    output logic [2:0]        alu_op_check,
    output logic [31:0]       register_data_out1_check,
    output logic [31:0]       register_data_out2_check,
    output logic [31:0]       b_input_check,
    output logic [31:0]       register_data_in_check,
    output logic [31:0]       alu_result_check,
    output logic              reg_write_check,
    output logic [31:0]       imm_ext_check,
    output logic              use_imm_check
`endif
);

    logic [31:0]       r_pc;
    logic [31:1][31:0] r_regs;

    logic [31:0][31:0] w_regs;
    logic [31:0]       w_instr;
    logic [6:0]        w_opcode;
    logic [4:0]        w_rd;
    logic [2:0]        w_funct3;
    logic [4:0]        w_rs1;
    logic [4:0]        w_rs2;
    logic [6:0]        w_funct7;
    logic              w_f7_base;
    logic [31:0]       w_imm_ext;
    logic [31:0]       w_rs1_data;
    logic [31:0]       w_rs2_data;
    logic [31:0]       w_b;
    logic [31:0]       w_alu_result;
    logic [31:0]       w_wb_data;
    alu_op_t           w_alu_op;
    logic              w_reg_write;
    logic              w_use_imm;
    logic              w_unused_init;

    instruction_memory u_imem (
        .clk                  (clk),
        .reset                (reset),
        .pc                   (r_pc),
        .initial_instructions (initial_instructions),
        .instruction          (w_instr)
    );

    assign w_opcode  = w_instr[6:0];
    assign w_rd      = w_instr[11:7];
    assign w_funct3  = w_instr[14:12];
    assign w_rs1     = w_instr[19:15];
    assign w_rs2     = w_instr[24:20];
    assign w_funct7  = w_instr[31:25];
    assign w_f7_base = (w_funct7 == F7_BASE);
    assign w_imm_ext = sext12(w_instr[31:20]);

    // x0 is hard-wired to zero; image slot 0 is never stored.
    assign w_regs        = {r_regs, 32'h0000_0000};
    assign w_unused_init = ^initial_register_values[0];

    assign w_rs1_data = w_regs[w_rs1];
    assign w_rs2_data = w_regs[w_rs2];

    always_comb begin
        w_alu_op    = ADD;
        w_reg_write = 1'b0;
        w_use_imm   = 1'b0;
        case (w_opcode)
            OPC_RTYPE: begin
                case (w_funct3)
                    F3_ADD: begin
                        w_alu_op    = (w_funct7 == F7_ALT) ? SUB : ADD;
                        w_reg_write = w_f7_base || (w_funct7 == F7_ALT);
                    end
                    F3_SLL:  begin w_alu_op = SLL; w_reg_write = w_f7_base; end
                    F3_SLT:  begin w_alu_op = SLT; w_reg_write = w_f7_base; end
                    F3_XOR:  begin w_alu_op = XOR; w_reg_write = w_f7_base; end
                    F3_SR:   begin w_alu_op = SRL; w_reg_write = w_f7_base; end
                    F3_OR:   begin w_alu_op = OR;  w_reg_write = w_f7_base; end
                    F3_AND:  begin w_alu_op = AND; w_reg_write = w_f7_base; end
                    default: w_reg_write = 1'b0;
                endcase
            end
            OPC_ITYPE: begin
                case (w_funct3)
                    F3_ADD:  begin w_alu_op = ADD; w_reg_write = 1'b1; end
                    F3_SLT:  begin w_alu_op = SLT; w_reg_write = 1'b1; end
                    F3_XOR:  begin w_alu_op = XOR; w_reg_write = 1'b1; end
                    F3_OR:   begin w_alu_op = OR;  w_reg_write = 1'b1; end
                    F3_AND:  begin w_alu_op = AND; w_reg_write = 1'b1; end
                    // Shift-immediates need imm[11:5]=0; SRAI and friends fall to NOP.
                    F3_SLL:  begin w_alu_op = SLL; w_reg_write = w_f7_base; end
                    F3_SR:   begin w_alu_op = SRL; w_reg_write = w_f7_base; end
                    default: w_reg_write = 1'b0;
                endcase
                w_use_imm = w_reg_write;
            end
            default: w_reg_write = 1'b0;
        endcase
        if (!w_reg_write) begin
            w_alu_op = ADD;
        end
    end

    assign w_b = w_use_imm ? w_imm_ext : w_rs2_data;

    alu u_alu (
        .a      (w_rs1_data),
        .b      (w_b),
        .alu_op (w_alu_op),
        .result (w_alu_result)
    );

    assign w_wb_data = w_alu_result;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc   <= '0;
            r_regs <= initial_register_values[31:1];
        end else begin
            r_pc <= r_pc + 32'd4;
            if (w_reg_write && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wb_data;
            end
        end
    end

`ifdef CPU_CORE_DEBUG_EN
    assign register_check           = w_regs;
    assign pc_out_check             = r_pc;
    assign instruction_check        = w_instr;
    assign alu_op_check             = w_alu_op;
    assign register_data_out1_check = w_rs1_data;
    assign register_data_out2_check = w_rs2_data;
    assign b_input_check            = w_b;
    assign register_data_in_check   = w_wb_data;
    assign alu_result_check         = w_alu_result;
    assign reg_write_check          = w_reg_write;
    assign imm_ext_check            = w_imm_ext;
    assign use_imm_check            = w_use_imm;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Directed bench for cpu_core: short program with hand-computed results plus ALU vectors.
module tb_cpu_core;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic [31:0][31:0] init_instr;
    logic [31:0][31:0] init_regs;

    logic [31:0][31:0] obs_regs;
    logic [31:0] obs_pc, obs_instr, obs_rs1, obs_rs2, obs_b, obs_wb, obs_res, obs_imm;
    logic [2:0]  obs_op;
    logic        obs_rw, obs_use_imm;

    logic [31:0] alu_a, alu_b, alu_res;
    alu_op_t     alu_sel;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

`ifdef CPU_CORE_DEBUG_EN
    cpu_core dut (
        .clk                      (clk),
        .reset                    (reset),
        .initial_instructions     (init_instr),
        .initial_register_values  (init_regs),
        .register_check           (obs_regs),
        .pc_out_check             (obs_pc),
        .instruction_check        (obs_instr),
        .alu_op_check             (obs_op),
        .register_data_out1_check (obs_rs1),
        .register_data_out2_check (obs_rs2),
        .b_input_check            (obs_b),
        .register_data_in_check   (obs_wb),
        .alu_result_check         (obs_res),
        .reg_write_check          (obs_rw),
        .imm_ext_check            (obs_imm),
        .use_imm_check            (obs_use_imm)
    );
`else
    cpu_core dut (
        .clk                     (clk),
        .reset                   (reset),
        .initial_instructions    (init_instr),
        .initial_register_values (init_regs)
    );
    assign obs_regs    = dut.w_regs;
    assign obs_pc      = dut.r_pc;
    assign obs_instr   = dut.w_instr;
    assign obs_op      = dut.w_alu_op;
    assign obs_rs1     = dut.w_rs1_data;
    assign obs_rs2     = dut.w_rs2_data;
    assign obs_b       = dut.w_b;
    assign obs_wb      = dut.w_wb_data;
    assign obs_res     = dut.w_alu_result;
    assign obs_rw      = dut.w_reg_write;
    assign obs_imm     = dut.w_imm_ext;
    assign obs_use_imm = dut.w_use_imm;
`endif

    alu u_alu_tb (
        .a      (alu_a),
        .b      (alu_b),
        .alu_op (alu_sel),
        .result (alu_res)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic alu_try(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input alu_op_t op, input logic [31:0] exp);
        alu_a   = a;
        alu_b   = b;
        alu_sel = op;
        #1;
        check_eq(tag, alu_res, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        init_instr = '0;
        for (int i = 0; i < 32; i++) init_regs[i] = 32'd3000 + 32'(i);
        init_instr[0] = 32'h005303b3;  // add  x7, x6, x5
        init_instr[1] = 32'h40848533;  // sub  x10, x9, x8
        init_instr[2] = 32'h00160693;  // addi x13, x12, 1
        init_instr[3] = 32'haaa08013;  // addi x0, x1, 0xaaa
        init_instr[4] = 32'h00000000;  // all-zero word
        init_instr[5] = 32'h4020d7b3;  // sra  x15, x1, x2 (unsupported)
        init_instr[6] = 32'h00409813;  // slli x16, x1, 4
        init_instr[7] = 32'h0020c8b3;  // xor  x17, x1, x2
        reset = 1'b1;
        alu_a = '0;
        alu_b = '0;
        alu_sel = ADD;

        alu_try("alu_add", 32'd4, 32'd2, ADD, 32'd6);
        alu_try("alu_sub", 32'd4, 32'd2, SUB, 32'd2);
        alu_try("alu_and", 32'd4, 32'd2, AND, 32'd0);
        alu_try("alu_or",  32'd4, 32'd2, OR,  32'd6);
        alu_try("alu_xor", 32'd4, 32'd2, XOR, 32'd6);
        alu_try("alu_sll", 32'd4, 32'd2, SLL, 32'd16);
        alu_try("alu_srl", 32'd4, 32'd2, SRL, 32'd1);
        alu_try("alu_slt", 32'd4, 32'd2, SLT, 32'd0);
        alu_try("alu_slt_neg", 32'hffffffff, 32'd0, SLT, 32'd1);
        alu_try("alu_slt_signed", 32'd2, 32'hfffffffd, SLT, 32'd0);
        alu_try("alu_sub_wrap", 32'd0, 32'd1, SUB, 32'hffffffff);
        alu_try("alu_srl_b40", 32'd8, 32'd33, SRL, 32'd4);
        alu_try("alu_sll_b40", 32'd1, 32'd35, SLL, 32'd8);

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // pc 0: add x7, x6, x5
        check_eq("rst_pc", obs_pc, 32'd0);
        check_eq("rst_x0", obs_regs[0], 32'd0);
        check_eq("rst_x7", obs_regs[7], 32'd3007);
        check_eq("add_instr", obs_instr, 32'h005303b3);
        check_eq("add_op", 32'(obs_op), 32'(ADD));
        check_eq("add_rs1", obs_rs1, 32'd3006);
        check_eq("add_rs2", obs_rs2, 32'd3005);
        check_eq("add_b", obs_b, 32'd3005);
        check_eq("add_res", obs_res, 32'd6011);
        check_eq("add_wb", obs_wb, 32'd6011);
        check_eq("add_use_imm", 32'(obs_use_imm), 32'd0);
        check_eq("add_rw", 32'(obs_rw), 32'd1);

        step();  // pc 4: sub x10, x9, x8
        check_eq("x7_written", obs_regs[7], 32'd6011);
        check_eq("sub_pc", obs_pc, 32'd4);
        check_eq("sub_instr", obs_instr, 32'h40848533);
        check_eq("sub_op", 32'(obs_op), 32'(SUB));
        check_eq("sub_res", obs_res, 32'd1);

        step();  // pc 8: addi x13, x12, 1
        check_eq("x10_written", obs_regs[10], 32'd1);
        check_eq("addi_pc", obs_pc, 32'd8);
        check_eq("addi_op", 32'(obs_op), 32'(ADD));
        check_eq("addi_use_imm", 32'(obs_use_imm), 32'd1);
        check_eq("addi_imm", obs_imm, 32'd1);
        check_eq("addi_b", obs_b, 32'd1);
        check_eq("addi_res", obs_res, 32'd3013);

        step();  // pc 12: addi x0, x1, 0xaaa
        check_eq("x13_written", obs_regs[13], 32'd3013);
        check_eq("neg_imm", obs_imm, 32'hfffffaaa);
        check_eq("neg_imm_res", obs_res, 32'd1635);
        check_eq("x0_dest_rw", 32'(obs_rw), 32'd1);

        step();  // pc 16: all-zero word
        check_eq("x0_after_write", obs_regs[0], 32'd0);
        check_eq("x1_untouched", obs_regs[1], 32'd3001);
        check_eq("nop_pc", obs_pc, 32'd16);
        check_eq("nop_rw", 32'(obs_rw), 32'd0);
        check_eq("nop_op", 32'(obs_op), 32'(ADD));

        step();  // pc 20: sra is not supported
        check_eq("nop_pc_inc", obs_pc, 32'd20);
        check_eq("nop_x7_kept", obs_regs[7], 32'd6011);
        check_eq("nop_x0_kept", obs_regs[0], 32'd0);
        check_eq("sra_rw", 32'(obs_rw), 32'd0);
        check_eq("sra_op", 32'(obs_op), 32'(ADD));

        step();  // pc 24: slli x16, x1, 4
        check_eq("sra_x15_kept", obs_regs[15], 32'd3015);
        check_eq("slli_op", 32'(obs_op), 32'(SLL));
        check_eq("slli_res", obs_res, 32'd48016);

        step();  // pc 28: xor x17, x1, x2
        check_eq("x16_written", obs_regs[16], 32'd48016);
        check_eq("xor_op", 32'(obs_op), 32'(XOR));
        check_eq("xor_res", obs_res, 32'd3);

        step();
        check_eq("x17_written", obs_regs[17], 32'd3);
        check_eq("pc_32", obs_pc, 32'd32);

        step();
        step();
        // Mid-run reset with a different first instruction in the image.
        init_instr[0] = 32'h0020c8b3;
        reset = 1'b1;
        #1;
        check_eq("mid_rst_pc", obs_pc, 32'd0);
        check_eq("mid_rst_x7", obs_regs[7], 32'd3007);
        check_eq("mid_rst_x16", obs_regs[16], 32'd3016);
        check_eq("mid_rst_x17", obs_regs[17], 32'd3017);
        check_eq("mid_rst_instr", obs_instr, 32'h0020c8b3);

        @(posedge clk);
        #1;
        check_eq("rst_holds_pc", obs_pc, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        check_eq("post_rst_x17", obs_regs[17], 32'd3);
        check_eq("post_rst_pc", obs_pc, 32'd4);
        check_eq("post_rst_instr", obs_instr, 32'h40848533);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock; reset  in  1  async active-high reset.
REQ-002 SHALL have initial_instructions  in  32x32  program image loaded into instruction memory on reset.
REQ-003 SHALL have initial_register_values  in  32x32  register image loaded on reset.
REQ-004 SHALL have register_check  out  32x32  live register file contents, index 0..31.
REQ-005 SHALL have pc_out_check  out  32  current PC.
REQ-006 SHALL have instruction_check  out  32  fetched instruction.
REQ-007 SHALL have alu_op_check  out  3  decoded ALU op.
REQ-008 SHALL have register_data_out1_check / register_data_out2_check  out  32 each  rs1/rs2 read data.
REQ-009 SHALL have b_input_check  out  32  ALU B operand.
REQ-010 SHALL have register_data_in_check  out  32  write-back data.
REQ-011 SHALL have alu_result_check  out  32  ALU result.
REQ-012 SHALL have reg_write_check  out  1  write-back enable; imm_ext_check  out  32  sign-extended immediate; use_imm_check  out  1  B-operand select (1 = immediate).

Function
REQ-013 SHALL be a single-cycle RV32I-subset core: fetch, decode, execute and write-back complete within one clk period; all *_check outputs combinational from current state.
REQ-014 Instruction memory SHALL be 32 words, combinational read, word index pc[6:2]; PC wraps modulo 128 bytes for fetch.
REQ-015 On each rising clk with reset low: PC <= PC+4; if reg_write and rd != 0, x[rd] <= alu_result.
REQ-016 x0 SHALL read as 0 and ignore writes regardless of initial image.
REQ-017 R-type (opcode 0110011): funct3/funct7 000/0000000 ADD, 000/0100000 SUB, 111 AND, 110 OR, 100 XOR, 001 SLL, 101/0000000 SRL, 010 SLT; use_imm=0.
REQ-018 I-type (opcode 0010011): funct3 000 ADDI, 111 ANDI, 110 ORI, 100 XORI, 010 SLTI, 001 SLLI, 101 SRLI (imm[11:5]=0); use_imm=1; imm_ext = sign-extend(instr[31:20]).
REQ-019 Any other opcode/funct combination (incl. all-zero word, SRA, SLTU) SHALL be a NOP: reg_write=0, alu_op=ADD, PC+4.
REQ-020 ALU: 32-bit wrap-around ADD/SUB; shifts use b[4:0]; SLT signed compare returning 1/0.
REQ-021 register_data_in SHALL equal alu_result.

Reset
REQ-022 While reset is high: PC=0, x1..x31 = initial_register_values, instruction memory = initial_instructions; reset wins over a coincident clk edge.
REQ-023 Reset asserted mid-program SHALL immediately return PC to 0 and restore both images.

Configuration
REQ-024 Macro CPU_CORE_DEBUG_EN: defined -> all *_check ports and register_check present; undefined -> those ports omitted, core function unchanged.

Structure
REQ-025 Package cpu_pkg SHALL hold alu_op_t (3-bit enum ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SLT=7) and opcode constants.
REQ-026 Sub-modules alu (a, b, alu_op -> result, combinational) and instruction_memory (pc, initial_instructions -> instruction).

Verification
REQ-027 Registers xi=3000+i, program [add x7,x6,x5; sub x10,x9,x8; addi x13,x12,1]; after reset: pc=0, instr=0x005303b3, op=ADD, rs1 data 3006, rs2 3005, result 6011, use_imm=0.
REQ-028 One clk later: x7=6011, pc=4, instr=0x40848533, op=SUB, result 1.
REQ-029 Next clk: pc=8, op=ADD, use_imm=1, imm_ext=1, b=1, result 3013; next clk x13=3013.
REQ-030 ALU a=4,b=2: ADD 6, SUB 2, AND 0, OR 6, XOR 6, SLL 16, SRL 1, SLT 0; a=-1,b=0 SLT 1.
REQ-031 addi with imm 0xAAA -> imm_ext 0xFFFFFAAA; write to x0 leaves register_check[0]=0.
REQ-032 All-zero instruction -> no register change, PC+4; reset mid-run -> pc=0, registers restored.
